// File: rtl/vec_relu_arbiter.sv
`default_nettype none
// =============================================================================
// vec_relu_arbiter : two-requester round-robin arbiter with burst lock and
//                    starvation cap, feeding a registered ReLU vector lane.
// Rev 1.0
// =============================================================================
module vec_relu_arbiter #(
   parameter int VEC_SIZE   = 4,
   parameter int EXP_WIDTH  = 8,
   parameter int FRAC_WIDTH = 23,
   parameter int MAX_BURST  = 16
) (
   input  logic                                             clk,
   input  logic                                             reset,
   input  logic                                             in0_valid,
   output logic                                             in0_ready,
   input  logic [VEC_SIZE*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]     in0_data,
   input  logic                                             in0_last,
   input  logic                                             in1_valid,
   output logic                                             in1_ready,
   input  logic [VEC_SIZE*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]     in1_data,
   input  logic                                             in1_last,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [VEC_SIZE*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]     out_data,
   output logic                                             out_src,
   output logic                                             out_last
);

   localparam int c_W   = 1 + EXP_WIDTH + FRAC_WIDTH;
   localparam int c_DW  = VEC_SIZE * c_W;
   localparam int c_CAP = (MAX_BURST == 0) ? 1 : MAX_BURST;
   localparam int c_CW  = $clog2(c_CAP + 1);
   localparam logic [c_CW-1:0] c_CAP_V = c_CW'(c_CAP);
   localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_LOCK = 1'b1
   } state_t;

   state_t            state_q;
   logic              owner_q;
   logic              prio_q;
   logic [c_CW-1:0]   cnt_q;
   logic              out_valid_q;
   logic [c_DW-1:0]   out_data_q;
   logic              out_src_q;
   logic              out_last_q;

   logic              w_grant;
   logic              w_preempt;
   logic              w_cap;
   logic              w_v_other;
   logic              w_can_load;
   logic              w_acc;
   logic [c_DW-1:0]   w_sel_data;
   logic              w_sel_last;
   logic [c_DW-1:0]   w_relu;

   always_comb begin
      w_v_other = owner_q ? in0_valid : in1_valid;
      w_cap     = (MAX_BURST != 0) && (cnt_q == c_CAP_V);
      w_preempt = 1'b0;
      w_grant   = prio_q;
      if (state_q == S_IDLE) begin
         if (in0_valid && !in1_valid)
            w_grant = 1'b0;
         else if (in1_valid && !in0_valid)
            w_grant = 1'b1;
      end else if (w_cap && w_v_other) begin
         // owner has used up its share while the other side waits
         w_grant   = ~owner_q;
         w_preempt = 1'b1;
      end else begin
         w_grant = owner_q;
      end
      w_can_load = !out_valid_q || out_ready;
      w_acc      = w_can_load && (w_grant ? in1_valid : in0_valid);
      w_sel_data = w_grant ? in1_data : in0_data;
      w_sel_last = w_grant ? in1_last : in0_last;
   end

   for (genvar i = 0; i < VEC_SIZE; i++) begin : g_relu
      assign w_relu[i*c_W +: c_W] = w_sel_data[i*c_W + c_W - 1] ? '0 : w_sel_data[i*c_W +: c_W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         prio_q      <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (w_acc) begin
         out_valid_q <= 1'b1;
         out_data_q  <= w_relu;
         out_src_q   <= w_grant;
         out_last_q  <= w_sel_last;
         if (state_q == S_IDLE) begin
            if (w_sel_last) begin
               prio_q <= ~w_grant;
            end else begin
               state_q <= S_LOCK;
               owner_q <= w_grant;
               cnt_q   <= c_ONE;
            end
         end else if (w_preempt) begin
            state_q <= S_IDLE;
            prio_q  <= w_grant;
            cnt_q   <= '0;
         end else if (w_sel_last) begin
            state_q <= S_IDLE;
            prio_q  <= ~owner_q;
            cnt_q   <= '0;
         end else if (cnt_q != c_CAP_V) begin
            cnt_q <= cnt_q + c_ONE;
         end
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign in0_ready = w_can_load && !w_grant;
   assign in1_ready = w_can_load && w_grant;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_relu_arbiter.sv
`default_nettype none
// =============================================================================
// tb_vec_relu_arbiter : scoreboard bench with directed and random traffic.
// Rev 1.0
// =============================================================================
module tb_vec_relu_arbiter;

   localparam int VS = 4;
   localparam int EW = 8;
   localparam int FW = 23;
   localparam int W  = 1 + EW + FW;
   localparam int DW = VS * W;
   localparam int MB = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          src;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in0_valid = 1'b0, in1_valid = 1'b0;
   logic          in0_ready, in1_ready;
   logic [DW-1:0] in0_data = '0, in1_data = '0;
   logic          in0_last = 1'b0, in1_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_src, out_last;

   int n_chk = 0;
   int n_err = 0;

   beat_t q0[$];
   beat_t q1[$];
   exp_t  sb[$];

   // reference state: occupancy, lock, owner, priority, burst count
   bit m_ov, m_lock, m_owner, m_prio;
   int m_cnt;

   vec_relu_arbiter #(
      .VEC_SIZE(VS), .EXP_WIDTH(EW), .FRAC_WIDTH(FW), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .reset(reset),
      .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_last(in0_last),
      .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_last(in1_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_src(out_src), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
      logic [DW-1:0] r;
      r = v;
      for (int i = 0; i < VS; i++)
         if (v[i*W + W - 1]) r[i*W +: W] = '0;
      return r;
   endfunction

   function automatic logic [DW-1:0] rnd_vec();
      logic [DW-1:0] v;
      for (int i = 0; i < VS; i++) v[i*W +: W] = $urandom;
      return v;
   endfunction

   task automatic push_burst(input int who, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = rnd_vec();
         b.last = (i == len - 1);
         if (who == 0) q0.push_back(b); else q1.push_back(b);
      end
   endtask

   // One clock cycle: drive inputs, check readies against the reference, book accepts.
   task automatic step(input bit rst, input bit want0, input bit want1, input bit ordy);
      bit g, pre, cl, v0, v1, lst;
      @(negedge clk);
      reset     = rst;
      out_ready = ordy;
      in0_valid = want0 && (q0.size() > 0);
      in1_valid = want1 && (q1.size() > 0);
      if (q0.size() > 0) begin in0_data = q0[0].data; in0_last = q0[0].last; end
      else begin in0_data = rnd_vec(); in0_last = $urandom_range(0, 1); end
      if (q1.size() > 0) begin in1_data = q1[0].data; in1_last = q1[0].last; end
      else begin in1_data = rnd_vec(); in1_last = $urandom_range(0, 1); end
      #1;
      if (rst) begin
         m_ov = 0; m_lock = 0; m_owner = 0; m_prio = 0; m_cnt = 0;
         sb.delete();
         return;
      end
      v0  = in0_valid;
      v1  = in1_valid;
      pre = 0;
      if (!m_lock)
         g = (v0 && !v1) ? 1'b0 : (v1 && !v0) ? 1'b1 : m_prio;
      else if (m_cnt == MB && (m_owner ? v0 : v1)) begin
         g = !m_owner; pre = 1;
      end else
         g = m_owner;
      cl = !m_ov || ordy;
      chk("in0_ready", in0_ready, cl && !g);
      chk("in1_ready", in1_ready, cl && g);
      chk("out_valid", out_valid, m_ov);
      if (cl && (g ? v1 : v0)) begin
         lst = g ? in1_last : in0_last;
         sb.push_back({relu(g ? in1_data : in0_data), g, lst});
         if (g) void'(q1.pop_front()); else void'(q0.pop_front());
         if (!m_lock) begin
            if (lst) m_prio = !g;
            else begin m_lock = 1; m_owner = g; m_cnt = 1; end
         end else if (pre) begin
            m_lock = 0; m_prio = g; m_cnt = 0;
         end else if (lst) begin
            m_lock = 0; m_prio = !m_owner; m_cnt = 0;
         end else if (m_cnt < MB) begin
            m_cnt++;
         end
         m_ov = 1;
      end else if (ordy) begin
         m_ov = 0;
      end
   endtask

   // Monitor: pops the scoreboard on every output transfer and checks hold stability.
   initial begin
      exp_t          e;
      bit            held = 0;
      logic [DW-1:0] h_data;
      logic          h_src, h_last;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            held = 0;
         end else begin
            if (held) begin
               chk("hold_data", out_data, h_data);
               chk("hold_src", out_src, h_src);
               chk("hold_last", out_last, h_last);
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_chk++; n_err++;
                  $display("FAIL out_extra: got beat src=%0d expected none", out_src);
               end else begin
                  e = sb.pop_front();
                  chk("out_data", out_data, e.data);
                  chk("out_src", out_src, e.src);
                  chk("out_last", out_last, e.last);
               end
            end
            held   = out_valid && !out_ready;
            h_data = out_data; h_src = out_src; h_last = out_last;
         end
      end
   end

   initial begin
      beat_t         b;
      logic [DW-1:0] c_in, c_out;
      c_in  = {32'hBF800000, 32'h3F800000, 32'h80000000, 32'h7FC00000};
      c_out = {32'h00000000, 32'h3F800000, 32'h00000000, 32'h7FC00000};

      // reset with both requesters valid
      b.data = c_in; b.last = 1'b1;
      q0.push_back(b);
      push_burst(1, 1);
      step(1, 1, 1, 1);
      step(1, 1, 1, 1);
      step(0, 1, 1, 1);
      chk("rst_out_valid", out_valid, 1'b0);
      step(0, 1, 1, 1);
      chk("first_data", out_data, c_out);
      chk("first_src", out_src, 1'b0);
      chk("next_grant1", in1_ready, 1'b1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

      // single-beat bursts alternate
      for (int i = 0; i < 4; i++) begin push_burst(0, 1); push_burst(1, 1); end
      for (int i = 0; i < 10; i++) step(0, 1, 1, 1);

      // 3-beat lock with requester 1 waiting
      push_burst(0, 3); push_burst(1, 2);
      for (int i = 0; i < 8; i++) step(0, 1, 1, 1);

      // 5-beat burst against the cap
      push_burst(0, 5); push_burst(1, 1); push_burst(1, 1);
      for (int i = 0; i < 12; i++) step(0, 1, 1, 1);

      // backpressure with a beat held
      push_burst(0, 2); push_burst(1, 2);
      step(0, 1, 1, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 1, 1);

      // reset mid-lock with the output occupied
      q0.delete(); q1.delete();
      push_burst(1, 4); push_burst(0, 2);
      step(0, 0, 1, 1);
      step(0, 0, 1, 0);
      step(1, 1, 1, 0);
      step(0, 1, 1, 1);
      chk("post_rst_valid", out_valid, 1'b0);
      chk("post_rst_in0_rdy", in0_ready, 1'b1);
      for (int i = 0; i < 8; i++) step(0, 1, 1, 1);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         if (q0.size() < 2) push_burst(0, $urandom_range(1, 6));
         if (q1.size() < 2) push_burst(1, $urandom_range(1, 6));
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
      end

      for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
      chk("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
